// File: rtl/ternary_result_encoder.sv
// ternary_result_encoder
// Drain-side converter: takes a signed WIDTH-bit accumulator word and emits it
// as a balanced-ternary trit stream, LSB trit first, one trit per cycle.
// Trit code: 00 = 0, 01 = +1, 10 = -1 (11 is never produced).
// Build option: define TERNARY_ENC_ZERO_TRIM_EN to end each frame after the
// most significant nonzero trit; otherwise every frame is NTRITS trits long.
module ternary_result_encoder #(
  parameter int WIDTH  = 32,
  parameter int NTRITS = 21,
  parameter int IDXW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_trit,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             out_ovf,
  output logic             busy,
  output logic [31:0]      frames_done
);

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  localparam logic [WIDTH:0]  MAG_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]  MAG_TWO  = (WIDTH+1)'(2);
  localparam logic [WIDTH:0]  MAG_DIV  = (WIDTH+1)'(3);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NTRITS - 1);

  state_t          r_state;
  logic            r_sign;
  logic [WIDTH:0]  r_mag;
  logic [IDXW-1:0] r_index;
  logic            r_ovf;
  logic [31:0]     r_frames;

  logic [WIDTH:0]  w_ext;
  logic [WIDTH:0]  w_abs;
  logic [WIDTH:0]  w_quot;
  logic [WIDTH:0]  w_rem;
  logic [WIDTH:0]  w_next_mag;
  logic            w_at_end;
  logic            w_last;
  logic [1:0]      w_trit;

  // Magnitude is one bit wider than the input so that -2^(WIDTH-1) is exact.
  assign w_ext = {in_value[WIDTH-1], in_value};
  assign w_abs = in_value[WIDTH-1] ? (~w_ext + MAG_ONE) : w_ext;

  // Constant divide-by-3 resolved in a single cycle.
  assign w_quot     = r_mag / MAG_DIV;
  assign w_rem      = r_mag % MAG_DIV;
  assign w_next_mag = (w_rem == MAG_TWO) ? (w_quot + MAG_ONE) : w_quot;

  assign w_at_end = (r_index == IDX_LAST);

`ifdef TERNARY_ENC_ZERO_TRIM_EN
  assign w_last = (r_state == S_EMIT) && (w_at_end || (w_next_mag == '0));
`else
  assign w_last = (r_state == S_EMIT) && w_at_end;
`endif

  // Digit selection; a negative word swaps +1 and -1 instead of negating mag.
  always_comb begin
    w_trit = 2'b00;
    if (r_state == S_EMIT) begin
      if (w_rem == MAG_ONE) begin
        w_trit = r_sign ? 2'b10 : 2'b01;
      end else if (w_rem == MAG_TWO) begin
        w_trit = r_sign ? 2'b01 : 2'b10;
      end
    end
  end

  // Frame FSM: latch a word in IDLE, step one digit per accepted trit in EMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_index  <= '0;
      r_ovf    <= 1'b0;
      r_frames <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign  <= in_value[WIDTH-1];
            r_mag   <= w_abs;
            r_ovf   <= in_ovf;
            r_index <= '0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_mag   <= w_next_mag;
            r_index <= r_index + IDXW'(1);
            if (w_last) begin
              r_state  <= S_IDLE;
              r_index  <= '0;
              r_frames <= r_frames + 32'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_EMIT);
  assign busy        = (r_state == S_EMIT);
  assign out_trit    = w_trit;
  assign out_index   = r_index;
  assign out_last    = w_last;
  assign out_ovf     = r_ovf;
  assign frames_done = r_frames;

endmodule

// File: doc/ternary_result_encoder.md
# ternary_result_encoder

Converts a signed 32-bit binary accumulator result back into a balanced-ternary trit stream, LSB trit first, using the fabric's 2-bit simple trit encoding. It sits at the drain side of a lane: it accepts finished accumulator words and serializes them for write-back to trit memory or the next fabric stage. Conversion is iterative, one trit per cycle, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32: accumulator width in bits, two's complement.
- NTRITS, 21: trits per frame in fixed-length mode. (3^21-1)/2 covers every 32-bit signed value.
- IDXW, 5: width of out_index, which must satisfy 2^IDXW ≥ NTRITS.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_value and in_ovf are valid.
- in_ready  out  1  encoder can accept a word.
- in_value  in  WIDTH  signed accumulator word.
- in_ovf  in  1  upstream overflow flag, carried with the frame.
- out_valid  out  1  out_trit is valid.
- out_ready  in  1  downstream accepts the trit.
- out_trit  out  2  00=0, 01=+1, 10=-1; 11 is never driven.
- out_index  out  IDXW  trit position within the frame, 0 for the LSB.
- out_last  out  1  final trit of the frame.
- out_ovf  out  1  in_ovf of the current frame; held for the whole frame.
- busy  out  1  a frame is in progress.
- frames_done  out  32  count of completed frames; wraps modulo 2^32.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Input accept (IDLE with in_valid): on that edge the block latches
  - sign = in_value[WIDTH-1];
  - mag = |in_value| as an unsigned WIDTH+1-bit value, so -2^31 is exact;
  - in_ovf;
  - index = 0.
  It then moves to EMIT.
- Digit rule, applied combinationally to mag:
  - r = mag mod 3, q = mag / 3.
  - r=0: trit 0, next mag = q.
  - r=1: trit +1, next mag = q.
  - r=2: trit -1, next mag = q+1.
  - If sign=1, +1 and -1 are swapped (free negation).
- Output transfer (out_valid && out_ready): mag ← next mag and index ← index+1.
  - If out_last was high, the block goes to IDLE and frames_done increments.
- out_last:
  - Fixed mode: index == NTRITS-1.
  - Trim mode: next mag == 0, or index == NTRITS-1.
- When out_ready=0, out_trit, out_index, out_last and out_ovf hold stable.
- Invariant: Σ trit_i·3^i = in_value for every frame.
- Reset (including mid-frame) forces every output to its reset value next, and the partial frame is discarded.
  - State = IDLE, so in_ready=1 and busy=0.
  - out_valid=0, out_trit=00, out_index=0, out_last=0, out_ovf=0.
  - frames_done=0.

## Timing
- Word accepted on edge N: out_valid=1 from cycle N+1, carrying trit 0.
- Throughput is one trit per cycle while out_ready=1.
- Last trit transferred on edge M: out_valid=0 and in_ready=1 in cycle M+1. That is one idle bubble between frames; in_ready is never asserted in EMIT.
- Frame length:
  - Fixed mode: NTRITS transfers.
  - Trim mode: 1 to NTRITS transfers; value 0 produces a single 0 trit.
- in_ready depends on state only and never combinationally on in_valid. out_valid does not depend on out_ready.
- The divide-by-3 must close timing combinationally within one cycle. No multicycle paths.

## Configuration
- TERNARY_ENC_ZERO_TRIM_EN defined: trim mode. The frame ends after the most significant nonzero trit, so out_last asserts when next mag==0.
- Not defined: fixed mode. Every frame is exactly NTRITS trits, padded with 0 trits, and out_last asserts only at index NTRITS-1.

## Test plan
- in_value=5, fixed mode, out_ready=1:
  - Trits in order: -1, -1, +1, then 18 × 0, i.e. out_trit 10, 10, 01, 00….
  - out_last at index 20, with out_valid one cycle after accept.
  - frames_done=1.
- in_value=-5, trim mode: exactly 3 trits 01, 01, 10, out_last on index 2, in_ready back high one cycle later.
- in_value=0 in trim mode gives a single trit 00 with out_last=1. in_value=0x80000000 in fixed mode gives 21 trits that the bench reconstructs to -2147483648 exactly, and no trit is 11.
- Backpressure on in_value=100 with in_ovf=1: hold out_ready=0 for 3 cycles mid-frame.
  - Outputs stay stable and out_ovf=1 throughout.
  - No trit is lost or duplicated, and the reconstructed value is 100.
- Reset at index 7 of a frame:
  - Next cycle: out_valid=0, in_ready=1, frames_done=0.
  - A new word (in_value=-1) then encodes correctly as 10, 00….
- Back-to-back random 32-bit values (1000 frames) with random out_ready:
  - Every frame reconstructs to its input.
  - frames_done=1000.
  - The bench checks in_valid held high with in_ready=0 in EMIT, and that no accept occurs during EMIT.
